// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and defaults for the two-port round-robin register-file arbiter.
package mem_rr_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // One-hot winner from two requests; pref=1 favours port 1 on contention.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic pref);
    if (req == 2'b11) return pref ? 2'b10 : 2'b01;
    return req;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle between the two masters and the arbiter (command in, grant/read data out).
interface mem_rr_arbiter_if
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );
endinterface

// File: rtl/mem_rr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; pointer moves to favour the loser on every accepted grant.
module rr_arb2
  import mem_rr_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);
  logic r_pref;

  assign o_grant = rr_pick(i_req, r_pref);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pref <= 1'b0;
    else if (i_accept && (|o_grant))
      r_pref <= o_grant[0];
  end
endmodule

// File: rtl/mem_rr_arbiter.sv
// Register-file memory shared by two masters: IDLE picks a winner, ACCESS performs one word op.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
)(
  input  logic           clk,
  input  logic           rst_n,
  mem_rr_arbiter_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t            r_state, w_next;
  logic [1:0]        w_req, w_grant;
  logic              w_accept;
  logic [1:0]        r_gnt, r_rvalid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_rd_op, w_wr_op;

  assign w_req = {bus.req1, bus.req0};

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_next   = ST_ACCESS;
          w_accept = 1'b1;
        end
      end
      ST_ACCESS: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_gnt <= w_accept ? w_grant : '0;
      if (w_accept) begin
        r_we    <= w_grant[0] ? bus.we0    : bus.we1;
        r_addr  <= w_grant[0] ? bus.addr0  : bus.addr1;
        r_wdata <= w_grant[0] ? bus.wdata0 : bus.wdata1;
      end
    end
  end

  // The grant is still high during ACCESS, so it doubles as the owner tag for rvalid.
  assign w_wr_op = (r_state == ST_ACCESS) &&  r_we;
  assign w_rd_op = (r_state == ST_ACCESS) && !r_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_op) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd_op ? r_gnt : '0;
      if (w_rd_op) r_rdata <= r_mem[r_addr];
    end
  end

  assign bus.gnt0    = r_gnt[0];
  assign bus.gnt1    = r_gnt[1];
  assign bus.rvalid0 = r_rvalid[0];
  assign bus.rvalid1 = r_rvalid[1];
  assign bus.rdata   = r_rdata;
  assign bus.busy    = (r_state == ST_ACCESS);
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  mem_rr_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A request seen while the memory is free is served: grant next cycle, read data the cycle after.
  int       cyc = 0;
  int       next_ok = 0;
  bit       m_pref = 1'b0;
  bit [7:0] m_mem [8];
  bit       e_g0 [4096], e_g1 [4096], e_busy [4096], e_rv0 [4096], e_rv1 [4096];
  bit [7:0] e_rd [4096];
  bit [7:0] m_rdata = 8'h00;

  logic       m_win, m_we;
  logic [2:0] m_addr;
  logic [7:0] m_wd;
  logic       m_any;
  assign m_any  = (bus.req0 === 1'b1) || (bus.req1 === 1'b1);
  assign m_win  = ((bus.req0 === 1'b1) && (bus.req1 === 1'b1)) ? m_pref : (bus.req1 === 1'b1);
  assign m_we   = m_win ? bus.we1 : bus.we0;
  assign m_addr = m_win ? bus.addr1 : bus.addr0;
  assign m_wd   = m_win ? bus.wdata1 : bus.wdata0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] <= 8'h00;
      m_pref  <= 1'b0;
      next_ok <= 0;
      for (int j = 1; j <= 2; j++) begin
        e_g0[cyc+j] <= 1'b0; e_g1[cyc+j] <= 1'b0; e_busy[cyc+j] <= 1'b0;
        e_rv0[cyc+j] <= 1'b0; e_rv1[cyc+j] <= 1'b0;
      end
    end else if (cyc >= next_ok && m_any) begin
      next_ok        <= cyc + 2;
      m_pref         <= ~m_win;
      e_busy[cyc+1]  <= 1'b1;
      if (m_win) e_g1[cyc+1] <= 1'b1;
      else       e_g0[cyc+1] <= 1'b1;
      if (m_we) begin
        m_mem[m_addr] <= m_wd;
      end else begin
        if (m_win) e_rv1[cyc+2] <= 1'b1;
        else       e_rv0[cyc+2] <= 1'b1;
        e_rd[cyc+2] <= m_mem[m_addr];
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt_exclusive", int'(bus.gnt0 & bus.gnt1), 0);
    if (!rst_n) begin
      chk("rst_gnt0", int'(bus.gnt0), 0);
      chk("rst_gnt1", int'(bus.gnt1), 0);
      chk("rst_rvalid0", int'(bus.rvalid0), 0);
      chk("rst_rvalid1", int'(bus.rvalid1), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_rdata", int'(bus.rdata), 0);
      m_rdata <= 8'h00;
    end else begin
      chk("gnt0", int'(bus.gnt0), int'(e_g0[cyc]));
      chk("gnt1", int'(bus.gnt1), int'(e_g1[cyc]));
      chk("busy", int'(bus.busy), int'(e_busy[cyc]));
      chk("rvalid0", int'(bus.rvalid0), int'(e_rv0[cyc]));
      chk("rvalid1", int'(bus.rvalid1), int'(e_rv1[cyc]));
      chk("rdata", int'(bus.rdata), int'((e_rv0[cyc] | e_rv1[cyc]) ? e_rd[cyc] : m_rdata));
      if (e_rv0[cyc] | e_rv1[cyc]) m_rdata <= e_rd[cyc];
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_access(input int p, input bit we, input bit [2:0] a, input bit [7:0] d,
                           output int lat);
    bit got = 1'b0;
    lat = 0;
    if (p == 0) begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      got = (p == 0) ? bus.gnt0 : bus.gnt1;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL grant_timeout: port %0d got no grant within 10 cycles, required one", p);
    end
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  task automatic read_check(input int p, input bit [2:0] a, input bit [7:0] exp);
    int lat;
    do_access(p, 1'b0, a, 8'h00, lat);
    @(posedge clk); #1;
    chk("lit_rvalid", int'(p == 0 ? bus.rvalid0 : bus.rvalid1), 1);
    chk("lit_rvalid_other", int'(p == 0 ? bus.rvalid1 : bus.rvalid0), 0);
    chk("lit_rdata", int'(bus.rdata), int'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int code;
    int exp3 [8] = '{1, 0, 2, 0, 1, 0, 2, 0};
    int exp4 [6] = '{2, 0, 2, 0, 2, 0};
    bit [2:0] wa;

    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // 1: reset state, memory reads back zero
    repeat (2) @(posedge clk);
    #1;
    chk("lit_reset_busy", int'(bus.busy), 0);
    chk("lit_reset_rdata", int'(bus.rdata), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) read_check(0, 3'(i), 8'h00);

    // 2: port 0 write then read of addr 3
    do_access(0, 1'b1, 3'd3, 8'hA5, lat);
    chk("lit_wr_latency", lat, 1);
    @(posedge clk); #1;
    do_access(0, 1'b0, 3'd3, 8'h00, lat);
    chk("lit_rd_latency", lat, 1);
    @(posedge clk); #1;
    chk("lit_t2_rvalid0", int'(bus.rvalid0), 1);
    chk("lit_t2_rvalid1", int'(bus.rvalid1), 0);
    chk("lit_t2_rdata", int'(bus.rdata), 8'hA5);

    // 3: continuous contention alternates starting with port 0
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      code = bus.gnt0 ? (bus.gnt1 ? 3 : 1) : (bus.gnt1 ? 2 : 0);
      chk("lit_contention_seq", code, exp3[k]);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 4: lone port 1 is served although the pointer favours port 0
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd2;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      code = bus.gnt0 ? (bus.gnt1 ? 3 : 1) : (bus.gnt1 ? 2 : 0);
      chk("lit_lone_port1_seq", code, exp4[k]);
    end
    bus.req1 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 5: fill via port 1, read back via port 0, address wrap
    for (int i = 0; i < 8; i++) do_access(1, 1'b1, 3'(i), 8'h10 + 8'(i), lat);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) read_check(0, 3'(i), 8'h10 + 8'(i));
    wa = 3'd7;
    wa = wa + 3'd1;
    do_access(1, 1'b1, wa, 8'h5A, lat);
    @(posedge clk); #1;
    read_check(0, 3'd0, 8'h5A);
    read_check(0, 3'd7, 8'h17);

    // 6: reset during a write access aborts it
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd5; bus.wdata0 = 8'hFF;
    @(posedge clk); #1;
    chk("lit_t6_gnt0", int'(bus.gnt0), 1);
    chk("lit_t6_busy", int'(bus.busy), 1);
    bus.req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("lit_t6_async_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    chk("lit_t6_rst_rvalid0", int'(bus.rvalid0), 0);
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd5;
    @(posedge clk); #1;
    chk("lit_t6_gnt_after_rst", int'(bus.gnt0), 1);
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    chk("lit_t6_rvalid0", int'(bus.rvalid0), 1);
    chk("lit_t6_mem5_zero", int'(bus.rdata), 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
